mmio_uart_tx: RTL and testbench
===============================

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: transmit FIFO entries; power of two, 2..8.
REQ-002 Parameter DEFAULT_DIV, default 16'd434: reset value of the DIVISOR register, in clocks per bit.
REQ-003 clk  input  1: sole clock; all state updates on posedge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 sel  input  1: address decoder hit for this peripheral.
REQ-006 addr  input  4: byte offset; addr[3:2] selects the register; addr[1:0] is ignored.
REQ-007 wdata  input  32: CPU store data.
REQ-008 wenable  input  4: per-byte write strobes, same encoding as the CPU mem_wenable.
REQ-009 rdata  output  32: combinational read data; 0 when sel=0.
REQ-010 tx  output  1: serial line, 8N1, LSB first, idle high.

Function
REQ-011 Register map: 0x0 DATA; 0x4 STATUS; 0x8 DIVISOR; 0xC reserved (reads 0, writes ignored).
REQ-012 A write occurs on a posedge where sel=1 and wenable!=0; reads have no side effects and are purely combinational from current state.
REQ-013 DATA write with wenable[0]=1: push wdata[7:0] if FIFO not full, evaluated before any same-cycle pop; if full, drop the byte and set overflow.
REQ-014 DATA read returns 0.
REQ-015 STATUS read: [0] busy (FSM!=IDLE), [1] full, [2] empty, [3] overflow, [7:4] FIFO count, [31:8] 0.
REQ-016 STATUS write with wenable[0]=1 and wdata[3]=1 clears overflow; an overflow event in the same cycle wins (overflow stays 1).
REQ-017 DIVISOR write: wenable[0] loads div[7:0]; wenable[1] loads div[15:8]; read returns {16'b0, div}.
REQ-018 Effective bit period = max(div,1) clocks, sampled once when a frame starts; a mid-frame DIVISOR write affects only the next frame.
REQ-019 FSM states: IDLE, START, DATA, STOP.
REQ-020 IDLE: tx=1; at a posedge with FIFO non-empty, pop the head into the shift register, load the bit counter, and go to START.
REQ-021 START: tx=0 for one bit period, then DATA.
REQ-022 DATA: tx=shift[0]; shift right each bit period; after 8 bits, go to STOP.
REQ-023 STOP: tx=1 for one bit period, then IDLE; a queued byte starts from IDLE on the next posedge, giving exactly one idle clock between frames.
REQ-024 Latency: DATA write at posedge N into an empty FIFO with FSM IDLE -> pop at N+1 -> tx low from N+1 for one bit period.
REQ-025 FIFO: circular buffer with wrapping read/write pointers; count 0..FIFO_DEPTH; simultaneous push and pop when not full and not empty leaves count unchanged.
REQ-026 A push into an empty FIFO is not poppable in the same cycle.
REQ-027 tx is driven from a register (glitch-free).

Reset
REQ-028 While rst_n=0: FSM=IDLE, tx=1, FIFO empty with pointers=0, count=0, overflow=0, div=DEFAULT_DIV, shift register and bit counter=0.
REQ-029 Reset asserted mid-frame aborts the frame immediately (tx=1 asynchronously) and discards FIFO contents.
REQ-030 rdata during reset reflects the reset register values (STATUS=0x004 when sel=1, addr=0x4).

Verification
REQ-031 div=4, write DATA=0x55 -> tx: 4 clk low, then bits 1,0,1,0,1,0,1,0 at 4 clk each, then 4 clk high; busy=1 for 40 clk; STATUS then 0x004.
REQ-032 div=4, 10 back-to-back DATA writes 0x00..0x09 with FIFO_DEPTH=8 -> 0x00 popped, 0x01..0x08 queued, 0x09 dropped, STATUS[3]=1 and count=8; tx emits 0x00..0x08 in order with one idle clk between frames.
REQ-033 Overflow set, then STATUS write wdata=0x8 -> overflow=0; same write coinciding with a full-FIFO DATA push is impossible on one port, so cover clear and overflow on consecutive cycles -> final overflow=1.
REQ-034 Write DIVISOR=0 -> bit period 1 clk, frame length 10 clk; DIVISOR write with wenable=4'b0010, wdata=0x0300 -> div=0x03xx, low byte preserved.
REQ-035 Mid-frame rst_n pulse during DATA bit 3 -> tx=1 immediately, STATUS=0x004 after release, and no residual bytes are transmitted.
REQ-036 sel=0 with any addr -> rdata=0, and writes have no effect.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx - memory-mapped 8N1 UART transmitter with a small transmit FIFO.
//
// Register map (addr[3:2] selects, addr[1:0] ignored):
//   0x0 DATA     write: queue wdata[7:0] (wenable[0]); read: 0
//   0x4 STATUS   read: [0] busy, [1] full, [2] empty, [3] overflow, [7:4] count
//                write: wenable[0] && wdata[3] clears overflow
//   0x8 DIVISOR  clocks per bit; wenable[0] -> div[7:0], wenable[1] -> div[15:8]
//   0xC reserved (reads 0, writes ignored)
//
// Ports:
//   clk      sole clock, posedge
//   rst_n    asynchronous active-low reset
//   sel      address decoder hit for this peripheral
//   addr     byte offset
//   wdata    CPU store data
//   wenable  per-byte write strobes
//   rdata    combinational read data (0 when sel=0)
//   tx       serial line, LSB first, idle high, registered
module mmio_uart_tx #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wenable,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_d;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               overflow;
  logic [15:0]        div;
  logic [7:0]         shift, shift_d;
  logic [2:0]         bit_cnt, bit_cnt_d;
  logic [15:0]        baud, baud_d;
  logic [15:0]        period, period_d;
  logic               tx_d;

  logic               wr_en, data_wr, stat_clr, div_wr_lo, div_wr_hi;
  logic               full, empty, push, pop, ovf_set;
  logic [1:0]         reg_idx;
  logic [15:0]        eff_div;
  logic [3:0]         count4;
  logic               unused_bits;

  assign unused_bits = ^{addr[1:0], wdata[31:16]};

  // Register decode
  assign reg_idx   = addr[3:2];
  assign wr_en     = sel && (wenable != 4'b0000);
  assign data_wr   = wr_en && (reg_idx == 2'd0) && wenable[0];
  assign stat_clr  = wr_en && (reg_idx == 2'd1) && wenable[0] && wdata[3];
  assign div_wr_lo = wr_en && (reg_idx == 2'd2) && wenable[0];
  assign div_wr_hi = wr_en && (reg_idx == 2'd2) && wenable[1];

  // Full is judged on the current count, so a push never relies on a same-cycle pop.
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push    = data_wr && !full;
  assign ovf_set = data_wr && full;
  assign count4  = 4'(count);

  // A divisor of 0 behaves as 1 clock per bit.
  assign eff_div = (div == 16'd0) ? 16'd1 : div;

  // FIFO storage carries no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // An overflow in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (stat_clr) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= DEFAULT_DIV;
    end else begin
      if (div_wr_lo) div[7:0]  <= wdata[7:0];
      if (div_wr_hi) div[15:8] <= wdata[15:8];
    end
  end

  // Transmit FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      baud    <= '0;
      period  <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_d;
      shift   <= shift_d;
      bit_cnt <= bit_cnt_d;
      baud    <= baud_d;
      period  <= period_d;
      tx      <= tx_d;
    end
  end

  // tx_d is the line level for the state being entered, so tx itself is a flop.
  // baud counts down from period-1; reaching 0 ends the current bit.
  always_comb begin
    state_d   = state;
    shift_d   = shift;
    bit_cnt_d = bit_cnt;
    baud_d    = baud;
    period_d  = period;
    tx_d      = tx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = mem[rd_ptr];
          bit_cnt_d = 3'd0;
          period_d  = eff_div;
          baud_d    = eff_div - 16'd1;
          tx_d      = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (baud == 16'd0) begin
          baud_d  = period - 16'd1;
          tx_d    = shift[0];
          state_d = DATA;
        end else begin
          baud_d = baud - 16'd1;
        end
      end
      DATA: begin
        if (baud == 16'd0) begin
          baud_d = period - 16'd1;
          if (bit_cnt == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d   = shift >> 1;
            tx_d      = shift[1];
            bit_cnt_d = bit_cnt + 3'd1;
          end
        end else begin
          baud_d = baud - 16'd1;
        end
      end
      STOP: begin
        if (baud == 16'd0) begin
          tx_d    = 1'b1;
          state_d = IDLE;
        end else begin
          baud_d = baud - 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (reg_idx)
        2'd1:    rdata = {24'd0, count4, overflow, empty, full, (state != IDLE)};
        2'd2:    rdata = {16'd0, div};
        default: rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed testbench for mmio_uart_tx: register access, frame timing,
// FIFO overflow, divisor handling, mid-frame reset and deselected access.
module tb_mmio_uart_tx;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wenable;
  logic [31:0] rdata;
  logic        tx;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd434)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sel     (sel),
    .addr    (addr),
    .wdata   (wdata),
    .wenable (wenable),
    .rdata   (rdata),
    .tx      (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One register write on the next posedge.
  task automatic wr(input logic s, input logic [3:0] a, input logic [31:0] d, input logic [3:0] we);
    @(negedge clk);
    sel = s; addr = a; wdata = d; wenable = we;
    @(posedge clk);
    #1;
    sel = 1'b0; wenable = 4'd0; wdata = 32'd0;
  endtask

  // Combinational read, checked within the current cycle.
  task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    sel = 1'b1; addr = a; wenable = 4'd0;
    #1;
    check(tag, rdata, exp);
  endtask

  // Frame sample k is taken after the k-th posedge counted from the pop edge (k=0).
  task automatic expect_frame(input logic [7:0] b, input int p, input int k0);
    logic [9:0] fr;
    logic       exp_bit;
    fr = {1'b1, b, 1'b0};
    sel = 1'b1; addr = 4'h4; wenable = 4'd0;
    for (int k = k0; k < 10 * p; k++) begin
      @(posedge clk);
      #1;
      exp_bit = fr[k / p];
      check($sformatf("tx_%02h_k%0d", b, k), {31'd0, tx}, {31'd0, exp_bit});
      check($sformatf("busy_%02h_k%0d", b, k), {31'd0, rdata[0]}, 32'd1);
    end
  endtask

  // The single idle clock between frames (or after the last one).
  task automatic expect_idle(input string tag);
    sel = 1'b1; addr = 4'h4; wenable = 4'd0;
    @(posedge clk);
    #1;
    check({tag, "_tx"}, {31'd0, tx}, 32'd1);
    check({tag, "_busy"}, {31'd0, rdata[0]}, 32'd0);
  endtask

  initial begin
    logic saw_low;
    rst_n = 1'b0; sel = 1'b0; addr = 4'd0; wdata = 32'd0; wenable = 4'd0;

    // Reset state
    #12;
    check("rst_tx", {31'd0, tx}, 32'd1);
    rd("rst_status", 4'h4, 32'h004);
    rd("rst_div", 4'h8, 32'd434);
    rd("rst_data", 4'h0, 32'd0);
    rd("rst_resv", 4'hC, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Deselected access
    sel = 1'b0; addr = 4'h4; #1;
    check("nosel_rd_status", rdata, 32'd0);
    addr = 4'h8; #1;
    check("nosel_rd_div", rdata, 32'd0);
    wr(1'b0, 4'h8, 32'h5, 4'hF);
    wr(1'b0, 4'h0, 32'h77, 4'h1);
    rd("nosel_div_kept", 4'h8, 32'd434);
    rd("nosel_no_push", 4'h4, 32'h004);

    // Reserved write and DATA write without byte-0 strobe
    wr(1'b1, 4'hC, 32'hFFFF_FFFF, 4'hF);
    rd("resv_rd", 4'hC, 32'd0);
    rd("resv_div_kept", 4'h8, 32'd434);
    wr(1'b1, 4'h0, 32'h0000_1234, 4'h2);
    rd("data_no_b0", 4'h4, 32'h004);

    // div=4, single 0x55 frame
    wr(1'b1, 4'h8, 32'h4, 4'h3);
    rd("div4", 4'h8, 32'd4);
    wr(1'b1, 4'h0, 32'h55, 4'h1);
    rd("q55_status", 4'h4, 32'h010);
    check("q55_tx_idle", {31'd0, tx}, 32'd1);
    expect_frame(8'h55, 4, 0);
    expect_idle("after55");
    rd("after55_status", 4'h4, 32'h004);

    // Ten back-to-back writes into a depth-8 FIFO
    for (int i = 0; i < 10; i++) wr(1'b1, 4'h0, i, 4'h1);
    rd("burst_status", 4'h4, 32'h08B);
    expect_frame(8'h00, 4, 9);
    for (int i = 1; i <= 8; i++) begin
      expect_idle($sformatf("gap%0d", i));
      expect_frame(8'(i), 4, 0);
    end
    expect_idle("burst_end");
    saw_low = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    check("no_byte09", {31'd0, saw_low}, 32'd0);
    rd("burst_ovf", 4'h4, 32'h00C);

    // Overflow clear, then clear and overflow on consecutive cycles
    wr(1'b1, 4'h4, 32'h8, 4'h1);
    rd("ovf_cleared", 4'h4, 32'h004);
    for (int i = 0; i < 9; i++) wr(1'b1, 4'h0, 32'hA0 + i, 4'h1);
    rd("fill_status", 4'h4, 32'h083);
    wr(1'b1, 4'h0, 32'hEE, 4'h1);
    rd("ovf_again", 4'h4, 32'h08B);
    wr(1'b1, 4'h4, 32'h8, 4'h1);
    rd("clr_full", 4'h4, 32'h083);
    wr(1'b1, 4'h0, 32'hEF, 4'h1);
    rd("ovf_final", 4'h4, 32'h08B);
    repeat (420) @(posedge clk);
    #1;
    rd("drained", 4'h4, 32'h00C);
    check("drained_tx", {31'd0, tx}, 32'd1);
    wr(1'b1, 4'h4, 32'h8, 4'h1);
    rd("drained_clr", 4'h4, 32'h004);

    // Divisor 0 acts as 1 clock per bit
    wr(1'b1, 4'h8, 32'h0, 4'h3);
    rd("div0", 4'h8, 32'd0);
    wr(1'b1, 4'h0, 32'hA5, 4'h1);
    expect_frame(8'hA5, 1, 0);
    expect_idle("afterA5");

    // Byte-1 strobe preserves the low byte
    wr(1'b1, 4'h8, 32'h12, 4'h1);
    wr(1'b1, 4'h8, 32'h0000_03FF, 4'h2);
    rd("div_hi_only", 4'h8, 32'h0312);

    // Mid-frame divisor write applies to the next frame only
    wr(1'b1, 4'h8, 32'h4, 4'h3);
    wr(1'b1, 4'h0, 32'h3C, 4'h1);
    wr(1'b1, 4'h0, 32'hC3, 4'h1);
    wr(1'b1, 4'h8, 32'h2, 4'h3);
    expect_frame(8'h3C, 4, 2);
    expect_idle("after3C");
    expect_frame(8'hC3, 2, 0);
    expect_idle("afterC3");

    // Reset during data bit 3 of 0x96 with 0x5A queued
    wr(1'b1, 4'h8, 32'h4, 4'h3);
    wr(1'b1, 4'h0, 32'h96, 4'h1);
    wr(1'b1, 4'h0, 32'h5A, 4'h1);
    repeat (17) @(posedge clk);
    #1;
    check("bit3_low", {31'd0, tx}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("async_tx_high", {31'd0, tx}, 32'd1);
    rd("in_rst_status", 4'h4, 32'h004);
    rd("in_rst_div", 4'h8, 32'd434);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd("post_rst_status", 4'h4, 32'h004);
    saw_low = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    check("no_residual", {31'd0, saw_low}, 32'd0);
    rd("final_status", 4'h4, 32'h004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
